// File: rtl/psum_collect_pkg.sv
// Shared types and constants for the PE-array result collector.
// Saturation markers match the array's clamped 8-bit write bus.
package psum_collect_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_e;

  localparam logic [7:0] SAT_POS   = 8'h7F;
  localparam logic [7:0] SAT_NEG   = 8'h80;
  localparam int         DEPTH_DEF = 9;

endpackage

// File: rtl/result_buffer.sv
// Frame storage: DEPTH x DATA_W registers, sync write, async read.
// Out-of-range addresses write nothing and read zero.
module result_buffer
  import psum_collect_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [CNT_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [CNT_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < DEPTH_C)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (raddr_i < DEPTH_C) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/psum_result_collector.sv
// Collects one frame of PE-array results, then drains it to the host
// over ready/valid while tracking saturation and protocol misuse.
module psum_result_collector
  import psum_collect_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [DATA_W-1:0] write_i,
  input  logic              capture_i,
  input  logic              frame_start_i,
  input  logic [CNT_W-1:0]  frame_len_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [CNT_W-1:0]  sat_count_o,
  output logic              overflow_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             we;
  logic             is_sat;
  logic             last;
  logic [CNT_W-1:0] len_clamp;
  logic [DATA_W-1:0] rdata;

  result_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_buf (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_q),
    .wdata_i (write_i),
    .raddr_i (rd_q),
    .rdata_o (rdata)
  );

  assign is_sat = (write_i == DATA_W'(SAT_POS)) ||
                  (write_i == DATA_W'(SAT_NEG));
  assign last   = (rd_q == len_q - ONE);

  // Zero or oversize requests mean a full output-stationary readout.
  assign len_clamp = ((frame_len_i == '0) || (frame_len_i > DEPTH_C)) ?
                     DEPTH_C : frame_len_i;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    len_d   = len_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          state_d = FILL;
          len_d   = len_clamp;
          wr_d    = '0;
          sat_d   = '0;
          ovf_d   = 1'b0;
        end else if (capture_i) begin
          ovf_d = 1'b1;
        end
      end
      FILL: begin
        if (frame_start_i) begin
          len_d = len_clamp;
          wr_d  = '0;
          sat_d = '0;
        end else if (capture_i) begin
          we   = 1'b1;
          wr_d = wr_q + ONE;
          if (is_sat && (sat_q != '1)) begin
            sat_d = sat_q + ONE;
          end
          if (wr_q + ONE == len_q) begin
            state_d = DRAIN;
            rd_d    = '0;
            done_d  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (capture_i || frame_start_i) begin
          ovf_d = 1'b1;
        end
        if (out_ready_i) begin
          rd_d = rd_q + ONE;
          if (last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      len_q   <= '0;
      sat_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      len_q   <= len_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign out_valid_o  = (state_q == DRAIN);
  assign out_data_o   = out_valid_o ? rdata : '0;
  assign out_last_o   = out_valid_o && last;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = done_q;
  assign sat_count_o  = sat_q;
  assign overflow_o   = ovf_q;

endmodule

// File: doc/psum_result_collector.md
Name: psum_result_collector

Overview:
- Output-side reader for the 3x3 PE array: samples the saturated 8-bit `write` result bus whenever the controller strobes a valid result.
- Buffers one frame of results, 1..9 values: 9 for an output-stationary 3x3 readout, fewer for row-stationary streams.
- Drains the frame to the host over a byte-wide ready/valid interface.
- Tracks saturated results and protocol misuse so the host can qualify a frame.

Parameters:
- DATA_W, 8, result width; matches the array write bus.
- DEPTH, 9, max results per frame (one per PE).
- CNT_W, 4, pointer/counter width; must satisfy 2**CNT_W > DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- write_i  in  DATA_W  saturated array result (two's complement, range 0x80..0x7F).
- capture_i  in  1  result-valid strobe from controller; one result per high cycle.
- frame_start_i  in  1  begin a new frame.
- frame_len_i  in  CNT_W  results expected in the frame; sampled on an accepted frame_start_i.
- out_data_o  out  DATA_W  result presented to host.
- out_valid_o  out  1  out_data_o valid.
- out_ready_i  in  1  host accepts out_data_o.
- out_last_o  out  1  final result of frame; qualified by out_valid_o.
- busy_o  out  1  high in FILL or DRAIN.
- frame_done_o  out  1  one-cycle pulse when FILL completes.
- sat_count_o  out  CNT_W  saturated results (0x7F or 0x80) captured in the current frame.
- overflow_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, RST=1) values:
  - state=IDLE; wr_ptr, rd_ptr, len and sat_count all 0.
  - out_valid_o, out_last_o, frame_done_o and overflow_o all 0.
  - out_data_o=0 via the mux default; buffer contents are don't-care.
- FSM states: IDLE, FILL, DRAIN. Next state and outputs are registered.
- IDLE:
  - frame_start_i=1 → FILL next cycle. Latch len = (frame_len_i==0 || frame_len_i>DEPTH) ? DEPTH : frame_len_i.
  - The same frame_start_i clears wr_ptr, sat_count and overflow_o.
  - capture_i in IDLE: data dropped, overflow_o set.
- FILL:
  - Each cycle with capture_i=1: mem[wr_ptr]<=write_i and wr_ptr++.
  - sat_count++ if write_i==0x7F or write_i==0x80; saturates at all-ones, no wrap.
  - On the capture that makes wr_ptr==len: next state DRAIN, frame_done_o pulses in the following cycle, rd_ptr<=0.
  - frame_start_i in FILL: restart. wr_ptr=0, sat_count=0, new len latched, stay in FILL. A capture_i in the same cycle is dropped; overflow_o is not set.
- DRAIN:
  - out_valid_o=1 and out_data_o=mem[rd_ptr]. out_valid_o rises the cycle after the final capture (latency 1).
  - out_last_o=1 when rd_ptr==len-1.
  - Transfer occurs when out_valid_o && out_ready_i: rd_ptr++.
  - Transfer with out_last_o → IDLE; out_valid_o low the next cycle.
  - out_data_o and out_last_o stay stable while out_valid_o && !out_ready_i.
  - capture_i or frame_start_i in DRAIN: ignored, overflow_o set. The frame in flight is unaffected.
- sat_count_o holds its value through DRAIN and IDLE until the next accepted frame_start_i.
- busy_o = (state != IDLE).
- Reset mid-FILL or mid-DRAIN: immediate return to reset values; any partial frame is discarded.
- No combinational path from out_ready_i to out_valid_o.

Decomposition:
- Shared package psum_collect_pkg:
  - state enum (IDLE, FILL, DRAIN);
  - constants SAT_POS=8'h7F and SAT_NEG=8'h80;
  - DEPTH default.
- One natural sub-module: result_buffer, a DEPTH x DATA_W register file with one sync write port and one async read port.

Test Plan:
- Full frame: frame_start, len=0 (→9), capture values 1..9 on consecutive cycles, out_ready_i=1 → frame_done pulses once; out_data_o=1..9 on 9 consecutive cycles; out_last_o only with 9; busy_o drops after.
- Short frame with backpressure: len=3, capture 0x7F, 0x05, 0x80; out_ready_i toggling 0/1 → data held stable while stalled; sequence 0x7F, 0x05, 0x80; out_last_o with 0x80; sat_count_o=2.
- Restart mid-FILL: len=9, capture 4 values, frame_start with len=2, capture 0x11, 0x22 → drains exactly 0x11, 0x22; sat_count_o=0; overflow_o=0.
- Misuse: capture_i in IDLE, then capture_i during DRAIN → overflow_o=1 and stays 1; DRAIN data unchanged; next accepted frame_start clears overflow_o.
- Async reset: assert RST mid-DRAIN with out_ready_i=0 → out_valid_o=0 immediately; state IDLE; sat_count_o=0; a subsequent len=1 frame with capture 0xFE drains 0xFE with out_last_o=1.
- Sat counter ceiling: len=9, all nine captures 0x80 → sat_count_o=9; DEPTH=9 never wraps the 4-bit counter.
